cnn_iter_ctrl: RTL and testbench
================================

// Module: cnn_iter_ctrl
// PURPOSE
//  Sequencer for the CNN cell-update datapath (Xnew = A*Y + B*U + I), run over a GRID_N x GRID_N cell array
//  for a programmed number of iterations. Fetches each cell's 3x3 Y/U neighbourhood from ping-pong state
//  memory and presents it to the combinational datapath. Applies the piecewise-linear output saturation and
//  writes the result to the opposite bank. Sits between the host start/done interface and the state memories.
// PARAMETERS
//  WIDTH   9   signed template/input width (A, B, U, I)
//  ACC_W   18  signed state/accumulator width (2*WIDTH)
//  GRID_N  16  cells per grid side; ADDR_W = $clog2(GRID_N*GRID_N)
//  ITER_W  8   width of iteration count
//  FRAC    6   fractional bits of Y; ONE = 1<<FRAC
// PORTS
//  clk        in   1              system clock
//  rst_n      in   1              asynchronous active-low reset
//  start      in   1              1-cycle pulse; accepted only in IDLE
//  iter_cnt   in   ITER_W         iterations to run; latched on accepted start
//  busy       out  1              high from the cycle after accepted start until done
//  done       out  1              1-cycle pulse at end of run
//  rd_en      out  1              state-memory read strobe
//  rd_addr    out  ADDR_W         read address, row*GRID_N+col
//  rd_bank    out  1              bank read this iteration
//  rd_y       in   ACC_W          Y read data, valid 1 cycle after rd_en
//  rd_u       in   WIDTH          U read data, valid 1 cycle after rd_en
//  nb_y       out  9*ACC_W        Y neighbourhood to datapath; k=0 top-left, row-major; k=4 centre; slice k = [k*ACC_W +: ACC_W]
//  nb_u       out  9*WIDTH        U neighbourhood, same ordering
//  dp_out     in   ACC_W          datapath result (combinational from nb_y/nb_u)
//  wr_en      out  1              write strobe, to bank ~rd_bank
//  wr_addr    out  ADDR_W         write address (current cell)
//  wr_data    out  ACC_W          saturated new state
// BEHAVIOUR
//  Clock/reset: one clock (clk); reset rst_n is asynchronous, active-low.
//  Reset: FSM=IDLE, busy=0, done=0, rd_en=0, wr_en=0, rd_bank=0, all addresses/nb registers=0.
//  FSM states: IDLE -> LOAD (k=0..8, 9 cycles) -> CAPT (1 cycle) -> WRITE (1 cycle) -> LOAD of next cell | FIN.
//  Each cell takes exactly 11 cycles. Cells are scanned row-major. After cell N*N-1 of an iteration,
//   rd_bank toggles and the iteration counter decrements.
//  LOAD: rd_en=1 only if neighbour k is inside the grid. Out-of-grid neighbours load 0 into both nb_y[k] and
//   nb_u[k] without a read (fixed zero boundary). Data is captured into slot k one cycle after issue;
//   the slot-8 capture occurs in CAPT.
//  WRITE: wr_en=1, wr_addr=cell, wr_data = sat(dp_out), where sat clamps to [-ONE, +ONE]. Sign-correct at both
//   rails; in-range values pass unchanged.
//  FIN: done=1 for one cycle, busy drops to 0 in the same cycle, then IDLE. rd_bank retains its value;
//   the final state is in bank rd_bank.
//  iter_cnt=0: no memory access; done pulses 2 cycles after start.
//  start while busy: ignored, with no effect on the run. Reset mid-run: immediate abort to the reset state;
//   partial writes are left in memory.
//  Total latency: iter_cnt*GRID_N^2*11 + 2 cycles from start to done.
// CONFIGURATION
//  CNN_CONVERGE_EN defined:
//   - Extra output port 'converged' (1 bit, reset 0).
//   - A per-iteration flag records whether any wr_data differed from that cell's old centre value (nb_y[4]).
//   - If an entire iteration has no change, the run ends at that iteration's end: FIN, converged=1,
//     held until the next accepted start.
//  CNN_CONVERGE_EN undefined: no 'converged' port; exactly iter_cnt iterations always run.
// STRUCTURE
//  cnn_pkg: WIDTH/ACC_W/FRAC defaults, ONE constant, FSM state typedef, nb index constants (NB_TL..NB_BR, NB_C=4).
//  Sub-module cnn_sat: combinational ACC_W clamp to +/-ONE; instantiated once on the write path.
//  Neighbour offset/boundary decode and counters remain in cnn_iter_ctrl.
// TESTING
//  1. GRID_N=4, iter_cnt=1, memory Y=0, dp_out=ONE/2 -> 16 writes of 32 at 11-cycle spacing; done at cycle 178; rd_bank=1.
//  2. Corner cell (0,0) -> rd_en only for k=4,5,7,8; nb slots 0,1,2,3,6 = 0.
//  3. dp_out=+200 / -200 / -17 (FRAC=6) -> wr_data=+64 / -64 / -17.
//  4. iter_cnt=0 -> done 2 cycles after start; rd_en and wr_en never asserted; second start while busy ignored.
//  5. rst_n low mid-LOAD of cell 5 -> all outputs 0 asynchronously; a fresh start runs a full sequence from cell 0.
//  6. (CNN_CONVERGE_EN) dp_out returns each cell's nb_y[4], iter_cnt=10 -> done after 1 iteration, converged=1.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and 3x3 neighbourhood indexing for the CNN iteration sequencer.
package cnn_pkg;

   localparam int DEF_WIDTH  = 9;
   localparam int DEF_ACC_W  = 18;
   localparam int DEF_GRID_N = 16;
   localparam int DEF_ITER_W = 8;
   localparam int DEF_FRAC   = 6;
   localparam int ONE        = 1 << DEF_FRAC;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_LOAD,
      ST_CAPT,
      ST_WRITE,
      ST_FIN
   } state_e;

   // Neighbourhood slots, row-major from top-left.
   localparam logic [3:0] NB_TL = 4'd0;
   localparam logic [3:0] NB_T  = 4'd1;
   localparam logic [3:0] NB_TR = 4'd2;
   localparam logic [3:0] NB_L  = 4'd3;
   localparam logic [3:0] NB_C  = 4'd4;
   localparam logic [3:0] NB_R  = 4'd5;
   localparam logic [3:0] NB_BL = 4'd6;
   localparam logic [3:0] NB_B  = 4'd7;
   localparam logic [3:0] NB_BR = 4'd8;

   function automatic int nb_row_off(input logic [3:0] k);
      case (k)
         NB_TL, NB_T, NB_TR: return -1;
         NB_L, NB_C, NB_R:   return 0;
         default:            return 1;
      endcase
   endfunction

   function automatic int nb_col_off(input logic [3:0] k);
      case (k)
         NB_TL, NB_L, NB_BL: return -1;
         NB_T, NB_C, NB_B:   return 0;
         default:            return 1;
      endcase
   endfunction

endpackage

// File: rtl/cnn_sat.sv
// Piecewise-linear output saturation: clamps a signed state value to [-ONE_V, +ONE_V].
module cnn_sat
   import cnn_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W,
   parameter int ONE_V = ONE
) (
   input  logic signed [ACC_W-1:0] din,
   output logic signed [ACC_W-1:0] dout
);

   localparam logic signed [ACC_W-1:0] POS_RAIL = ACC_W'(ONE_V);
   localparam logic signed [ACC_W-1:0] NEG_RAIL = -POS_RAIL;

   always_comb begin
      if (din > POS_RAIL)      dout = POS_RAIL;
      else if (din < NEG_RAIL) dout = NEG_RAIL;
      else                     dout = din;
   end

endmodule

// File: rtl/cnn_iter_ctrl.sv
// Iteration sequencer for the CNN cell-update datapath over a ping-pong state memory.
// Optional CNN_CONVERGE_EN adds a 'converged' output and early termination on a no-change iteration.
module cnn_iter_ctrl
   import cnn_pkg::*;
#(
   parameter  int WIDTH  = DEF_WIDTH,
   parameter  int ACC_W  = DEF_ACC_W,
   parameter  int GRID_N = DEF_GRID_N,
   parameter  int ITER_W = DEF_ITER_W,
   parameter  int FRAC   = DEF_FRAC,
   localparam int ADDR_W = $clog2(GRID_N * GRID_N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ITER_W-1:0]    iter_cnt,
   output logic                 busy,
   output logic                 done,
   output logic                 rd_en,
   output logic [ADDR_W-1:0]    rd_addr,
   output logic                 rd_bank,
   input  logic [ACC_W-1:0]     rd_y,
   input  logic [WIDTH-1:0]     rd_u,
   output logic [9*ACC_W-1:0]   nb_y,
   output logic [9*WIDTH-1:0]   nb_u,
   input  logic [ACC_W-1:0]     dp_out,
   output logic                 wr_en,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [ACC_W-1:0]     wr_data
`ifdef CNN_CONVERGE_EN
   ,
   output logic                 converged
`endif
);

   localparam int RC_W = (GRID_N > 1) ? $clog2(GRID_N) : 1;
   localparam logic [RC_W-1:0] LAST_RC = RC_W'(GRID_N - 1);

   state_e              state_q, state_d;
   logic [3:0]          k_q, k_d;
   logic [RC_W-1:0]     row_q, row_d, col_q, col_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic                bank_q, bank_d;
   logic [ACC_W-1:0]    nb_y_q [9];
   logic [ACC_W-1:0]    nb_y_d [9];
   logic [WIDTH-1:0]    nb_u_q [9];
   logic [WIDTH-1:0]    nb_u_d [9];
   logic                cap_en, cap_in;
   logic [3:0]          cap_k;
   logic signed [ACC_W-1:0] sat_out;
`ifdef CNN_CONVERGE_EN
   logic                changed_q, changed_d, conv_q, conv_d, changed_now;
`endif

   function automatic logic nb_inside(input logic [RC_W-1:0] row, input logic [RC_W-1:0] col,
                                      input logic [3:0] k);
      int r, c;
      r = int'(row) + nb_row_off(k);
      c = int'(col) + nb_col_off(k);
      return (r >= 0) && (r < GRID_N) && (c >= 0) && (c < GRID_N);
   endfunction

   function automatic logic [ADDR_W-1:0] nb_addr(input logic [RC_W-1:0] row, input logic [RC_W-1:0] col,
                                                 input logic [3:0] k);
      int r, c;
      r = int'(row) + nb_row_off(k);
      c = int'(col) + nb_col_off(k);
      return ADDR_W'(r * GRID_N + c);
   endfunction

   cnn_sat #(.ACC_W(ACC_W), .ONE_V(1 << FRAC)) u_sat (
      .din  (dp_out),
      .dout (sat_out)
   );

`ifdef CNN_CONVERGE_EN
   assign changed_now = changed_q | (sat_out != nb_y_q[NB_C]);
`endif

   // NOTE: every variable is given a default before the case, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      row_d   = row_q;
      col_d   = col_q;
      iter_d  = iter_q;
      bank_d  = bank_q;
      nb_y_d  = nb_y_q;
      nb_u_d  = nb_u_q;
      cap_en  = 1'b0;
      cap_k   = NB_TL;
`ifdef CNN_CONVERGE_EN
      changed_d = changed_q;
      conv_d    = conv_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SETUP;
               iter_d  = iter_cnt;
               row_d   = '0;
               col_d   = '0;
               k_d     = NB_TL;
`ifdef CNN_CONVERGE_EN
               changed_d = 1'b0;
               conv_d    = 1'b0;
`endif
            end
         end
         ST_SETUP: state_d = (iter_q == '0) ? ST_FIN : ST_LOAD;
         ST_LOAD: begin
            // Read data arrives one cycle after issue, so each cycle captures the previous slot.
            if (k_q != NB_TL) begin
               cap_en = 1'b1;
               cap_k  = k_q - 4'd1;
            end
            if (k_q == NB_BR) state_d = ST_CAPT;
            else              k_d     = k_q + 4'd1;
         end
         ST_CAPT: begin
            cap_en  = 1'b1;
            cap_k   = NB_BR;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            state_d = ST_LOAD;
            k_d     = NB_TL;
`ifdef CNN_CONVERGE_EN
            changed_d = changed_now;
`endif
            if (col_q == LAST_RC) begin
               col_d = '0;
               if (row_q == LAST_RC) begin
                  row_d  = '0;
                  bank_d = ~bank_q;
                  iter_d = iter_q - ITER_W'(1);
                  if (iter_q == ITER_W'(1)) state_d = ST_FIN;
`ifdef CNN_CONVERGE_EN
                  changed_d = 1'b0;
                  if (!changed_now) begin
                     state_d = ST_FIN;
                     conv_d  = 1'b1;
                  end
`endif
               end else begin
                  row_d = row_q + RC_W'(1);
               end
            end else begin
               col_d = col_q + RC_W'(1);
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      cap_in = nb_inside(row_q, col_q, cap_k);
      if (cap_en) begin
         nb_y_d[cap_k] = cap_in ? rd_y : '0;
         nb_u_d[cap_k] = cap_in ? rd_u : '0;
      end
   end

   // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
         iter_q  <= '0;
         bank_q  <= 1'b0;
         // NOTE: the neighbourhood array is a handful of output-visible registers, not a RAM, so it is reset.
         for (int i = 0; i < 9; i++) begin
            nb_y_q[i] <= '0;
            nb_u_q[i] <= '0;
         end
`ifdef CNN_CONVERGE_EN
         changed_q <= 1'b0;
         conv_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         row_q   <= row_d;
         col_q   <= col_d;
         iter_q  <= iter_d;
         bank_q  <= bank_d;
         nb_y_q  <= nb_y_d;
         nb_u_q  <= nb_u_d;
`ifdef CNN_CONVERGE_EN
         changed_q <= changed_d;
         conv_q    <= conv_d;
`endif
      end
   end

   always_comb begin
      busy    = (state_q == ST_SETUP) || (state_q == ST_LOAD) ||
                (state_q == ST_CAPT)  || (state_q == ST_WRITE);
      done    = (state_q == ST_FIN);
      rd_bank = bank_q;
      rd_en   = (state_q == ST_LOAD) && nb_inside(row_q, col_q, k_q);
      rd_addr = rd_en ? nb_addr(row_q, col_q, k_q) : '0;
      wr_en   = (state_q == ST_WRITE);
      wr_addr = wr_en ? nb_addr(row_q, col_q, NB_C) : '0;
      wr_data = wr_en ? sat_out : '0;
      for (int k = 0; k < 9; k++) begin
         nb_y[k*ACC_W +: ACC_W] = nb_y_q[k];
         nb_u[k*WIDTH +: WIDTH] = nb_u_q[k];
      end
   end

`ifdef CNN_CONVERGE_EN
   assign converged = conv_q;
`endif

endmodule

// File: tb/tb_cnn_iter_ctrl.sv
// Self-checking bench for cnn_iter_ctrl on a 4x4 grid with a behavioural memory and Jacobi reference model.
module tb_cnn_iter_ctrl;

   localparam int WIDTH  = 9;
   localparam int ACC_W  = 18;
   localparam int GRID_N = 4;
   localparam int CELLS  = GRID_N * GRID_N;
   localparam int ADDR_W = 4;

   logic                clk;
   logic                rst_n;
   logic                start;
   logic [7:0]          iter_cnt;
   logic                busy, done, rd_en, rd_bank, wr_en;
   logic [ADDR_W-1:0]   rd_addr, wr_addr;
   logic [ACC_W-1:0]    rd_y, dp_out, wr_data;
   logic [WIDTH-1:0]    rd_u;
   logic [9*ACC_W-1:0]  nb_y;
   logic [9*WIDTH-1:0]  nb_u;
`ifdef CNN_CONVERGE_EN
   logic                converged;
`endif

   cnn_iter_ctrl #(.GRID_N(GRID_N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .iter_cnt (iter_cnt),
      .busy     (busy),
      .done     (done),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_bank  (rd_bank),
      .rd_y     (rd_y),
      .rd_u     (rd_u),
      .nb_y     (nb_y),
      .nb_u     (nb_u),
      .dp_out   (dp_out),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
`ifdef CNN_CONVERGE_EN
      ,
      .converged(converged)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural state memory: two Y banks, one U plane, 1-cycle read latency.
   logic [ACC_W-1:0] mem_y [2][CELLS];
   logic [WIDTH-1:0] mem_u [CELLS];
   logic [ACC_W-1:0] init_y [CELLS];
   logic [WIDTH-1:0] init_u [CELLS];
   logic             do_init = 1'b0;
   logic [ACC_W-1:0] rd_y_r;
   logic [WIDTH-1:0] rd_u_r;

   always @(posedge clk) begin
      if (do_init) begin
         for (int a = 0; a < CELLS; a++) begin
            mem_y[0][a] <= init_y[a];
            mem_y[1][a] <= init_y[a];
            mem_u[a]    <= init_u[a];
         end
      end else begin
         if (rd_en) begin
            rd_y_r <= mem_y[rd_bank][rd_addr];
            rd_u_r <= mem_u[rd_addr];
         end
         if (wr_en) mem_y[~rd_bank][wr_addr] <= wr_data;
      end
   end
   assign rd_y = rd_y_r;
   assign rd_u = rd_u_r;

   // Datapath stand-in: constant, neighbourhood sum, or centre pass-through.
   int               dp_mode;
   logic [ACC_W-1:0] dp_const;
   always_comb begin
      int s;
      s = 0;
      for (int k = 0; k < 9; k++)
         s += int'($signed(nb_y[k*ACC_W +: ACC_W])) + int'($signed(nb_u[k*WIDTH +: WIDTH]));
      case (dp_mode)
         0:       dp_out = dp_const;
         1:       dp_out = ACC_W'(s);
         default: dp_out = nb_y[4*ACC_W +: ACC_W];
      endcase
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [ADDR_W-1:0] wr_a_q [$];
   logic [ACC_W-1:0]  wr_d_q [$];
   int                wr_c_q [$];
   logic [8:0]        rd_mask;
   logic [9*ACC_W-1:0] snap_y;
   logic [9*WIDTH-1:0] snap_u;
   int                run_s;
   logic              busy_at_done;

   task automatic load_mem();
      @(negedge clk);
      do_init = 1'b1;
      @(negedge clk);
      do_init = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Pulse start with n iterations, optionally a second start at step 'extra_at', and log until done.
   task automatic run(input logic [7:0] n, input int extra_at, input logic [7:0] extra_n,
                      output int lat, output int nrd, output int nwr);
      int  budget;
      bit  got;
      budget = int'(n) * CELLS * 11 + 40;
      got = 1'b0;
      lat = -1;
      nrd = 0;
      nwr = 0;
      rd_mask = '0;
      wr_a_q.delete();
      wr_d_q.delete();
      wr_c_q.delete();
      @(negedge clk);
      iter_cnt = n;
      start = 1'b1;
      run_s = cyc;
      for (int i = 1; i <= budget && !got; i++) begin
         @(negedge clk);
         start = (i == extra_at);
         if (i == extra_at) iter_cnt = extra_n;
         if (rd_en) begin
            nrd++;
            if (cyc - run_s - 2 >= 0 && cyc - run_s - 2 <= 8) rd_mask[cyc - run_s - 2] = 1'b1;
         end
         if (wr_en) begin
            if (wr_a_q.size() == 0) begin
               snap_y = nb_y;
               snap_u = nb_u;
            end
            wr_a_q.push_back(wr_addr);
            wr_d_q.push_back(wr_data);
            wr_c_q.push_back(cyc);
            nwr++;
         end
         if (done) begin
            got = 1'b1;
            lat = cyc - run_s;
            busy_at_done = busy;
         end
      end
      start = 1'b0;
      check("done_seen", 64'(got), 64'd1);
   endtask

   function automatic int sat_i(input int v);
      if (v > 64)  return 64;
      if (v < -64) return -64;
      return v;
   endfunction

   int lat, nrd, nwr, bad_sp, n_it;
   logic [ACC_W-1:0] e18;
   int sat_in  [8] = '{200, -200, -17, 64, 65, -64, -65, 0};
   int sat_exp [8] = '{64, -64, -17, 64, 64, -64, -64, 0};
   int corner_src [9] = '{-1, -1, -1, -1, 0, 1, -1, 4, 5};
   int my [CELLS];
   int mu [CELLS];
   int nw [CELLS];

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      iter_cnt = '0;
      dp_mode = 0;
      dp_const = '0;
      for (int a = 0; a < CELLS; a++) begin
         init_y[a] = '0;
         init_u[a] = '0;
      end
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_busy",    64'(busy), 64'd0);
      check("rst_done",    64'(done), 64'd0);
      check("rst_rd_en",   64'(rd_en), 64'd0);
      check("rst_wr_en",   64'(wr_en), 64'd0);
      check("rst_rd_bank", 64'(rd_bank), 64'd0);
      check("rst_rd_addr", 64'(rd_addr), 64'd0);
      check("rst_wr_addr", 64'(wr_addr), 64'd0);
      check("rst_wr_data", 64'(wr_data), 64'd0);
      check("rst_nb_zero", 64'((nb_y == '0) && (nb_u == '0)), 64'd1);
      rst_n = 1'b1;

      // One iteration, Y=0, constant datapath ONE/2
      for (int a = 0; a < CELLS; a++) init_u[a] = WIDTH'($urandom_range(80) - 40);
      load_mem();
      dp_mode = 0;
      dp_const = 18'd32;
      run(8'd1, 0, 8'd0, lat, nrd, nwr);
      check("t1_latency", 64'(lat), 64'd178);
      check("t1_writes",  64'(nwr), 64'd16);
      check("t1_reads",   64'(nrd), 64'd100);
      check("t1_busy_at_done", 64'(busy_at_done), 64'd0);
      check("t1_rd_bank", 64'(rd_bank), 64'd1);
      check("t1_first_wr_cycle", 64'(wr_c_q[0] - run_s), 64'd12);
      check("t2_corner_rd_mask", 64'(rd_mask), 64'h1B0);
      bad_sp = 0;
      for (int i = 0; i < wr_a_q.size(); i++) begin
         check($sformatf("t1_wr_addr_%0d", i), 64'(wr_a_q[i]), 64'(i));
         check($sformatf("t1_wr_data_%0d", i), 64'(wr_d_q[i]), 64'd32);
         if (i > 0 && wr_c_q[i] - wr_c_q[i-1] != 11) bad_sp++;
      end
      check("t1_wr_spacing_bad", 64'(bad_sp), 64'd0);

      // Asynchronous reset during LOAD of cell 5 (row 1, col 1; slot 3 reads cell 4)
      @(negedge clk);
      iter_cnt = 8'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (59) @(negedge clk);
      check("t5_pre_rd_en",   64'(rd_en), 64'd1);
      check("t5_pre_rd_addr", 64'(rd_addr), 64'd4);
      #1 rst_n = 1'b0;
      #1;
      check("t5_busy",    64'(busy), 64'd0);
      check("t5_rd_en",   64'(rd_en), 64'd0);
      check("t5_rd_addr", 64'(rd_addr), 64'd0);
      check("t5_rd_bank", 64'(rd_bank), 64'd0);
      check("t5_wr_en",   64'(wr_en), 64'd0);
      check("t5_done",    64'(done), 64'd0);
      check("t5_nb_zero", 64'((nb_y == '0) && (nb_u == '0)), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run(8'd1, 0, 8'd0, lat, nrd, nwr);
      check("t5_rerun_latency", 64'(lat), 64'd178);
      check("t5_rerun_first_addr", 64'(wr_a_q[0]), 64'd0);
      check("t5_rerun_writes", 64'(nwr), 64'd16);

      // Saturation at and around both rails
      for (int t = 0; t < 8; t++) begin
         dp_const = ACC_W'(sat_in[t]);
         run(8'd1, 0, 8'd0, lat, nrd, nwr);
         e18 = ACC_W'(sat_exp[t]);
         check($sformatf("t3_sat_%0d", sat_in[t]), 64'(wr_d_q[0]), 64'(e18));
      end

      // Zero iterations, plus a start during SETUP that must be ignored
      run(8'd0, 1, 8'd5, lat, nrd, nwr);
      check("t4_latency", 64'(lat), 64'd2);
      check("t4_reads",   64'(nrd), 64'd0);
      check("t4_writes",  64'(nwr), 64'd0);
      repeat (4) @(negedge clk);
      check("t4_idle_busy", 64'(busy), 64'd0);

      // Start while busy mid-run is ignored
      run(8'd1, 50, 8'd3, lat, nrd, nwr);
      check("t4b_latency", 64'(lat), 64'd178);
      check("t4b_writes",  64'(nwr), 64'd16);

      // Randomised multi-iteration run against a Jacobi reference model
      do_reset();
      for (int a = 0; a < CELLS; a++) begin
         init_y[a] = ACC_W'($urandom_range(160) - 80);
         init_u[a] = WIDTH'($urandom_range(80) - 40);
         my[a] = int'($signed(init_y[a]));
         mu[a] = int'($signed(init_u[a]));
      end
      load_mem();
      n_it = int'($urandom_range(3, 1));
      for (int it = 0; it < n_it; it++) begin
         for (int r = 0; r < GRID_N; r++)
            for (int c = 0; c < GRID_N; c++) begin
               int s;
               s = 0;
               for (int rr = r - 1; rr <= r + 1; rr++)
                  for (int cc = c - 1; cc <= c + 1; cc++)
                     if (rr >= 0 && rr < GRID_N && cc >= 0 && cc < GRID_N)
                        s += my[rr*GRID_N + cc] + mu[rr*GRID_N + cc];
               nw[r*GRID_N + c] = sat_i(s);
            end
         my = nw;
      end
      dp_mode = 1;
      run(8'(n_it), 0, 8'd0, lat, nrd, nwr);
      check("rnd_latency", 64'(lat), 64'(n_it * CELLS * 11 + 2));
      check("rnd_writes",  64'(nwr), 64'(n_it * CELLS));
      check("rnd_rd_bank", 64'(rd_bank), 64'(n_it % 2));
      for (int k = 0; k < 9; k++) begin
         logic [ACC_W-1:0] ey;
         logic [WIDTH-1:0] eu;
         ey = (corner_src[k] < 0) ? '0 : init_y[corner_src[k]];
         eu = (corner_src[k] < 0) ? '0 : init_u[corner_src[k]];
         check($sformatf("t2_nb_y_%0d", k), 64'(snap_y[k*ACC_W +: ACC_W]), 64'(ey));
         check($sformatf("t2_nb_u_%0d", k), 64'(snap_u[k*WIDTH +: WIDTH]), 64'(eu));
      end
      for (int a = 0; a < CELLS; a++) begin
         e18 = ACC_W'(my[a]);
         check($sformatf("rnd_state_%0d", a), 64'(mem_y[n_it % 2][a]), 64'(e18));
      end

      // Centre pass-through datapath: converges after one iteration when enabled
      for (int a = 0; a < CELLS; a++) init_y[a] = ACC_W'($urandom_range(128) - 64);
      load_mem();
      dp_mode = 2;
`ifdef CNN_CONVERGE_EN
      run(8'd10, 0, 8'd0, lat, nrd, nwr);
      check("t6_latency",  64'(lat), 64'd178);
      check("t6_writes",   64'(nwr), 64'd16);
      repeat (3) @(negedge clk);
      check("t6_converged_held", 64'(converged), 64'd1);
      dp_mode = 0;
      dp_const = 18'd40;
      run(8'd1, 0, 8'd0, lat, nrd, nwr);
      check("t6_converged_cleared", 64'(converged), 64'd0);
`else
      run(8'd2, 0, 8'd0, lat, nrd, nwr);
      check("t6_full_latency", 64'(lat), 64'd354);
      check("t6_full_writes",  64'(nwr), 64'd32);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
